// File: rtl/mprjram_wb_ctrl.sv
// Wishbone slave in front of the user-project BRAM (mprjram window).
// Every access takes a fixed DELAYS cycles from request to a one-cycle ack.
module mprjram_wb_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DELAYS    = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              oor_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  // Reads hit the BRAM one cycle earlier than writes so the registered read
  // data can be captured before the shared ack cycle.
  localparam logic [7:0]  RD_MEM_CYC = 8'(DELAYS - 2);
  localparam logic [7:0]  WR_MEM_CYC = 8'(DELAYS - 1);
  localparam logic [22:0] WORD_LIMIT = 23'(1) << ADDR_W;

  logic [2:0]        state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [3:0]        sel_reg;
  logic [31:0]       wdata_reg;
  logic              in_range_reg;
  logic [31:0]       rdata_reg;
  logic              oor_reg;

  logic       seg_hit;
  logic       in_range;
  logic       req;
  logic       capture;
  logic [7:0] first_mem_cyc;
  logic [7:0] mem_cyc;
  logic [7:0] cnt_inc;
  logic       mem_active;
  logic       unused_adr;

  assign seg_hit       = (wbs_adr_i[31:24] == ADDR_BASE[31:24]);
  assign in_range      = seg_hit && ({1'b0, wbs_adr_i[23:2]} < WORD_LIMIT);
  assign req           = wbs_cyc_i && wbs_stb_i;
  assign capture       = (state_reg == S_IDLE) && req && seg_hit;
  assign first_mem_cyc = wbs_we_i ? WR_MEM_CYC : RD_MEM_CYC;
  assign mem_cyc       = we_reg ? WR_MEM_CYC : RD_MEM_CYC;
  assign cnt_inc       = cnt_reg + 8'd1;
  assign unused_adr    = ^wbs_adr_i[1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = 8'd0;
        if (capture) begin
          cnt_next   = 8'd1;
          state_next = (first_mem_cyc == 8'd1) ? S_MEM : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_next = S_IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == mem_cyc) state_next = S_MEM;
        end
      end
      S_MEM: begin
        // An abort here still lets the write strobe of this cycle reach the BRAM.
        cnt_next = cnt_inc;
        if (!req)        state_next = S_IDLE;
        else if (we_reg) state_next = S_ACK;
        else             state_next = S_CAP;
      end
      S_CAP: begin
        cnt_next   = cnt_inc;
        state_next = S_ACK;
      end
      S_ACK: begin
        cnt_next   = 8'd0;
        state_next = S_IDLE;
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= 4'd0;
      wdata_reg    <= 32'd0;
      in_range_reg <= 1'b0;
      oor_reg      <= 1'b0;
    end else if (capture) begin
      addr_reg     <= wbs_adr_i[ADDR_W+1:2];
      we_reg       <= wbs_we_i;
      sel_reg      <= wbs_sel_i;
      wdata_reg    <= wbs_dat_i;
      in_range_reg <= in_range;
      if (!in_range) oor_reg <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rdata_reg <= 32'd0;
    end else if (state_reg == S_CAP) begin
      rdata_reg <= in_range_reg ? bram_rdata : 32'd0;
    end
  end

  assign mem_active = (state_reg == S_MEM) && in_range_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bram_we[gi] = mem_active && we_reg && sel_reg[gi];
  end

  assign bram_en    = mem_active;
  assign bram_addr  = addr_reg;
  assign bram_wdata = wdata_reg;
  assign wbs_ack_o  = (state_reg == S_ACK);
  assign wbs_dat_o  = rdata_reg;
  assign oor_o      = oor_reg;

endmodule

// File: doc/mprjram_wb_ctrl.md
Name: mprjram_wb_ctrl

Overview:
- Wishbone slave that fronts the user-project BRAM (mprjram, base 0x3800_0000) from which firmware fetches and runs matmul().
- Sits between the Caravel user-area Wishbone bus and a single-port, byte-writable BRAM macro.
- Inserts a fixed, parameterised access latency to model slow off-core memory.
- Every instruction fetch and data access made by the firmware that drives the checkbits result sequence passes through this block.

Parameters:
- ADDR_BASE, 32'h3800_0000, window base; the decode compares bits [31:24] only.
- ADDR_W, 10, BRAM word-address width (4 KiB = 1024 x 32 bit).
- DELAYS, 10, cycles from request to ack; legal range 3..255.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte lane enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data
- bram_en  out  1  BRAM port enable
- bram_we  out  4  BRAM byte write enables
- bram_addr  out  ADDR_W  BRAM word address
- bram_wdata  out  32  BRAM write data
- bram_rdata  in  32  BRAM read data, valid 1 cycle after bram_en
- oor_o  out  1  sticky flag: out-of-range access inside the 0x38 segment

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous and active-low on wb_rst_n.
- Reset values: all outputs 0, FSM in IDLE, counter 0.
- Decode:
  - seg_hit = wbs_adr_i[31:24] == ADDR_BASE[31:24].
  - in_range = seg_hit && wbs_adr_i[23:2] < 2**ADDR_W.
  - Word address = wbs_adr_i[ADDR_W+1:2].
  - If seg_hit is false the request is ignored: no ack, no state change.
- Request capture:
  - In IDLE, cycle 0 is the first cycle in which cyc&stb&seg_hit is high.
  - adr, we, sel, dat and in_range are latched at the end of cycle 0.
- FSM states:
  - IDLE -> WAIT: on capture; the counter loads 1.
  - WAIT: the counter increments each cycle.
    - Read: moves to MEM when counter == DELAYS-2.
    - Write: moves to MEM when counter == DELAYS-1.
  - MEM (read, cycle DELAYS-2): bram_en=1, bram_we=0, bram_addr=latched address. Next state CAP.
  - CAP (read, cycle DELAYS-1): bram_rdata is registered into wbs_dat_o; the register loads 0 if out of range. Next state ACK.
  - MEM (write, cycle DELAYS-1): bram_en=1, bram_we=sel, bram_wdata=dat. Next state ACK.
  - ACK (cycle DELAYS): wbs_ack_o=1 for exactly one cycle. Next state IDLE.
- Out-of-range (seg_hit && !in_range):
  - Same latency and an ack are produced.
  - bram_en and bram_we stay 0; read data is 0.
  - oor_o sets and stays set until reset.
- Latency: ack always appears in cycle DELAYS, for both reads and writes.
- Sustained rate: one transfer per DELAYS+1 cycles. The next request can be captured in the cycle after ack.
- wbs_dat_o holds its value until the next read's CAP.
- bram_en and bram_we are 0 in every cycle except MEM.
- Abort: if cyc or stb drops while in WAIT or MEM:
  - Return to IDLE on the next edge with no ack.
  - A write whose MEM cycle has not yet occurred is never issued.
  - A write already in MEM completes to the BRAM, but is not acked.
- Input changes: changes to wbs_adr_i, wbs_dat_i or wbs_sel_i after capture are ignored.
- sel = 4'b0000 write: the full handshake runs and ack is given, but bram_we stays 0.
- Reset asserted mid-transaction: all outputs clear immediately. No ack and no BRAM write follow after reset releases.

Test Plan:
- Read latency: preload word 0 = 32'h1234_5678; read 0x3800_0000 with DELAYS=10 -> bram_en high in cycle 8 only; ack high in cycle 10 only; wbs_dat_o = 32'h1234_5678.
- Byte-lane write: write 0xAABB_CCDD with sel=4'b0101 to 0x3800_0004 over a word holding 0 -> bram_we=4'b0101 in cycle 9; ack in cycle 10; read-back = 32'h00BB_00DD.
- Decode: access 0x3000_0000 -> no ack for 50 cycles and bram_en stays 0. Access 0x3800_1000 (word 1024) -> ack at cycle 10; data 0; oor_o=1 and stays 1.
- Back-to-back: 16 sequential reads of 0x3800_0000..0x3800_003C -> each ack exactly 11 cycles apart; data matches the preload; each ack lasts one cycle.
- Abort and reset: drop stb in cycle 5 of a write -> no ack and no bram_we; word unchanged. Assert wb_rst_n low in cycle 7 of a read -> wbs_ack_o and wbs_dat_o go 0 immediately and no ack follows release.
- Firmware run: full SoC matmul from mprjram with DELAYS=10 -> checkbits sequence AB40, 40, 893, 2541, 2669, 3233, 4267, 4622, 5681, 6023, 9073, AB51 is reached before the 250k-cycle timeout.
